// File: rtl/seq_mul16.sv
// Unsigned 16x16 sequential shift-add multiplier: one partial-product step per clock,
// 16-bit carry-lookahead adder in the step, 32-bit registered product.
module seq_mul16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [31:0] P,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [15:0] mcand;
  logic [32:0] acc;
  logic [3:0]  cnt;

  logic [15:0] addend;
  logic [15:0] sum;
  logic        co;
  logic        carry_keep;
  logic [32:0] acc_shift;
  logic        last_step;

  // Carries c1..c4 of a 4-bit lookahead unit, fully expanded (no ripple).
  function automatic logic [4:1] lookahead4(input logic [3:0] g, input logic [3:0] p,
                                             input logic cin);
    logic [4:1] c;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

  // Two-level CLA: four 4-bit groups, group generate/propagate fed to a second lookahead unit.
  function automatic logic [16:0] cla16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] g;
    logic [15:0] p;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:1]  cb;
    logic [4:1]  ct;
    logic [3:0]  bin;
    logic [16:0] c;
    g = a & b;
    p = a ^ b;
    for (int k = 0; k < 4; k++) begin
      ct    = lookahead4(g[4*k +: 4], p[4*k +: 4], 1'b0);
      gg[k] = ct[4];
      gp[k] = &p[4*k +: 4];
    end
    cb  = lookahead4(gg, gp, 1'b0);
    bin = {cb[3:1], 1'b0};
    c   = '0;
    for (int k = 0; k < 4; k++) begin
      ct              = lookahead4(g[4*k +: 4], p[4*k +: 4], bin[k]);
      c[4*k + 1 +: 4] = ct;
    end
    return {cb[4], p ^ c[15:0]};
  endfunction

  assign addend    = acc[0] ? mcand : 16'h0000;
  assign {co, sum} = cla16(acc[31:16], addend);
  // acc[32] is always zero entering a step; the OR keeps the retained-carry bit on the add path.
  assign carry_keep = co | acc[32];
  assign acc_shift  = {1'b0, carry_keep, sum, acc[15:1]};
  assign last_step  = (cnt == 4'd15);

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: if (start) state_next = CALC;
      CALC: begin
        busy = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      P     <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand <= A;
            acc   <= {17'b0, B};
            cnt   <= '0;
          end
        end
        CALC: begin
          acc <= acc_shift;
          cnt <= cnt + 4'd1;
          if (last_step) P <= acc_shift[31:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul16.sv
// Scoreboard bench for seq_mul16: the driver pushes expected product and done cycle,
// a negedge monitor pops and compares whenever done is presented.
module tb_seq_mul16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic [31:0] P;
  logic        busy;
  logic        done;

  typedef struct {
    logic [31:0] p;
    int          done_cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc    = 0;
  int          n_cmp  = 0;
  int          n_bad  = 0;
  logic [31:0] last_p = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_mul16 dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .P    (P),
    .busy (busy),
    .done (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!busy && !done) return;
      @(negedge clk);
    end
    fail("idle_timeout");
  endtask

  // Called at a negedge; start is seen on the following rising edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [31:0] expp,
                       input bit keep, output int acc_cyc);
    wait_idle();
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    check("busy_after_start", 32'(busy), 32'd1);
    start = 1'b0;
    A     = 16'($urandom);
    B     = 16'($urandom);
    if (keep) sb.push_back('{expp, acc_cyc + 16});
  endtask

  initial begin : monitor
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_done) check("done_one_cycle", 32'(done), 32'd0);
      if (busy) check("p_hold_calc", P, last_p);
      if (done) begin
        check("busy_in_done", 32'(busy), 32'd0);
        if (sb.size() == 0) begin
          fail("unexpected_done");
        end else begin
          e = sb.pop_front();
          check("product", P, e.p);
          check("done_cycle", 32'(cyc), 32'(e.done_cyc));
        end
        last_p = P;
      end
      prev_done = done;
    end
  end

  initial begin : driver
    int a1;
    int a2;
    int rel_cyc;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] dir_a [12] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h8000,
                                16'h1234, 16'hABCD, 16'h0001, 16'h8000, 16'h7FFF, 16'h0000};
    logic [15:0] dir_b [12] = '{16'h0000, 16'hFFFF, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF,
                                16'h5678, 16'h0002, 16'h0001, 16'h0001, 16'h8000, 16'hFFFF};
    logic [31:0] dir_p [12] = '{32'h00000000, 32'h0000FFFF, 32'h0000FFFF, 32'h3FFF0001,
                                32'h7FFF8000, 32'h7FFF8000, 32'h06260060, 32'h0001579A,
                                32'h00000001, 32'h00008000, 32'h3FFF8000, 32'h00000000};

    rst   = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    #1 rst = 1'b1;
    #2;
    check("reset_p", P, 32'h0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    issue(16'h0003, 16'h0005, 32'h0000000F, 1'b1, a1);
    issue(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1, a1);

    // Zero operands back to back: second start in the IDLE cycle after done.
    issue(16'h1234, 16'h0000, 32'h00000000, 1'b1, a1);
    issue(16'h0000, 16'hABCD, 32'h00000000, 1'b1, a2);
    check("b2b_accept", 32'(a2), 32'(a1 + 18));

    // Start held through CALC and DONE is only taken once back in IDLE.
    issue(16'h00FF, 16'h0100, 32'h0000FF00, 1'b1, a1);
    A     = 16'h0001;
    B     = 16'h0001;
    start = 1'b1;
    sb.push_back('{32'h00000001, a1 + 18 + 16});
    wait_idle();
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;

    // Reset mid-CALC aborts with no done; first edge after release accepts start.
    issue(16'h8000, 16'h8000, 32'h0, 1'b0, a1);
    repeat (7) @(negedge clk);
    rst    = 1'b1;
    last_p = '0;
    #1;
    check("midreset_p", P, 32'h0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    rel_cyc = cyc;
    issue(16'h8000, 16'h8000, 32'h40000000, 1'b1, a2);
    check("accept_after_reset", 32'(a2), 32'(rel_cyc + 1));

    for (int i = 0; i < 12; i++) issue(dir_a[i], dir_b[i], dir_p[i], 1'b1, a1);

    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      issue(ra, rb, 32'(ra) * 32'(rb), 1'b1, a1);
    end

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) fail("pending_results");
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
